// File: rtl/sys_mem_arb.sv
// sys_mem_arb: arbitrates NUM_AGENTS request ports onto one sys_mem port.
// An arbitration cycle in IDLE picks a winner (round-robin or fixed priority).
// The winner then owns the port for up to BURST_MAX accepted beats.
// Read responses return in order and are steered back to their agent through a tag FIFO.
// Optional feature macro: SYS_MEM_ARB_STATS_EN enables the per-agent accepted-beat counters.
//
// Handshake: a command is offered on sys_mem_wren/sys_mem_rden. It is accepted in the
// same cycle when sys_mem_wait is 0. An agent's beat is accepted on any cycle in which
// it has a request and its agt_wait is 0.
module sys_mem_arb #(
    parameter int NUM_AGENTS     = 4,
    parameter int SYS_MEM_DATA_W = 32,
    parameter int SYS_MEM_ADDR_W = 27,
    parameter int ARB_MODE       = 0,
    parameter int BURST_MAX      = 8,
    parameter int RD_TAG_DEPTH   = 16
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic [NUM_AGENTS-1:0]                         agt_wren,
    input  logic [NUM_AGENTS-1:0]                         agt_rden,
    input  logic [NUM_AGENTS-1:0][SYS_MEM_ADDR_W-1:0]     agt_addr,
    input  logic [NUM_AGENTS-1:0][SYS_MEM_DATA_W-1:0]     agt_wdata,
    output logic [NUM_AGENTS-1:0]                         agt_wait,
    output logic [NUM_AGENTS-1:0]                         agt_rd_valid,
    output logic [NUM_AGENTS-1:0][SYS_MEM_DATA_W-1:0]     agt_rdata,
    output logic                                          sys_mem_wren,
    output logic                                          sys_mem_rden,
    output logic [SYS_MEM_ADDR_W-1:0]                     sys_mem_addr,
    output logic [SYS_MEM_DATA_W-1:0]                     sys_mem_wdata,
    input  logic                                          sys_mem_wait,
    input  logic                                          sys_mem_rd_valid,
    input  logic [SYS_MEM_DATA_W-1:0]                     sys_mem_rdata,
    output logic                                          err_orphan_rd,
    input  logic                                          stat_clr,
    output logic [NUM_AGENTS-1:0][15:0]                   stat_beats,
    output logic                                          dbg_state
);

    localparam int AGW  = $clog2(NUM_AGENTS);
    localparam int TAGW = $clog2(RD_TAG_DEPTH);
    localparam int CNTW = $clog2(BURST_MAX + 1);

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [AGW-1:0]      grant_id_q, grant_id_d;
    logic [AGW-1:0]      rr_ptr_q, rr_ptr_d;
    logic [CNTW-1:0]     beat_cnt_q, beat_cnt_d;

    logic [NUM_AGENTS-1:0] agt_req;
    logic [AGW-1:0]        win_id;
    logic                  win_found;
    logic                  own;
    logic                  g_wren;
    logic                  g_rden;
    logic                  rd_hold;
    logic                  accept;

    logic [AGW-1:0]        tag_mem [RD_TAG_DEPTH];
    logic [TAGW-1:0]       tag_wr_ptr, tag_rd_ptr;
    logic [TAGW:0]         tag_cnt;
    logic                  tag_full, tag_empty;
    logic                  tag_push, tag_pop;
    logic [AGW-1:0]        tag_head;

    // A write wins over a simultaneous read from the same agent.
    assign agt_req   = agt_wren | agt_rden;
    assign dbg_state = (state_q == OWN);

    // Winner selection: round-robin scans upward from rr_ptr+1, fixed priority takes lowest index.
    always_comb begin
        win_id    = '0;
        win_found = 1'b0;
        if (ARB_MODE == 1) begin
            for (int i = NUM_AGENTS - 1; i >= 0; i--) begin
                if (agt_req[i]) begin
                    win_id = AGW'(i);
                end
            end
        end else begin
            for (int k = 1; k <= NUM_AGENTS; k++) begin
                int idx;
                idx = (int'(rr_ptr_q) + k) % NUM_AGENTS;
                if (!win_found && agt_req[idx]) begin
                    win_found = 1'b1;
                    win_id    = AGW'(idx);
                end
            end
        end
    end

    // Command mux: only the owning agent reaches the memory port; held reads stay off the bus.
    always_comb begin
        own           = (state_q == OWN) && !rst;
        g_wren        = agt_wren[grant_id_q];
        g_rden        = agt_rden[grant_id_q] & ~g_wren;
        rd_hold       = g_rden & tag_full;
        sys_mem_wren  = own & g_wren;
        sys_mem_rden  = own & g_rden & ~tag_full;
        sys_mem_addr  = own ? agt_addr[grant_id_q]  : '0;
        sys_mem_wdata = own ? agt_wdata[grant_id_q] : '0;
        accept        = (sys_mem_wren | sys_mem_rden) & ~sys_mem_wait;
        agt_wait      = '1;
        if (own && !sys_mem_wait && !rd_hold) begin
            agt_wait[grant_id_q] = 1'b0;
        end
    end

    // Next-state: arbitrate in IDLE, release the port on a dropped request or a full burst.
    always_comb begin
        state_d    = state_q;
        grant_id_d = grant_id_q;
        rr_ptr_d   = rr_ptr_q;
        beat_cnt_d = beat_cnt_q;
        case (state_q)
            IDLE: begin
                if (|agt_req) begin
                    grant_id_d = win_id;
                    beat_cnt_d = '0;
                    state_d    = OWN;
                end
            end
            OWN: begin
                if (!agt_req[grant_id_q]) begin
                    state_d    = IDLE;
                    rr_ptr_d   = grant_id_q;
                    beat_cnt_d = '0;
                end else if (accept) begin
                    if (beat_cnt_q == CNTW'(BURST_MAX - 1)) begin
                        state_d    = IDLE;
                        rr_ptr_d   = grant_id_q;
                        beat_cnt_d = '0;
                    end else begin
                        beat_cnt_d = beat_cnt_q + CNTW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Arbiter state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            grant_id_q <= '0;
            rr_ptr_q   <= AGW'(NUM_AGENTS - 1);
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            grant_id_q <= grant_id_d;
            rr_ptr_q   <= rr_ptr_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    assign tag_full  = (tag_cnt == (TAGW+1)'(RD_TAG_DEPTH));
    assign tag_empty = (tag_cnt == '0);
    assign tag_push  = accept & sys_mem_rden;
    assign tag_pop   = sys_mem_rd_valid & ~tag_empty & ~rst;
    assign tag_head  = tag_mem[tag_rd_ptr];

    // Tag FIFO pointers and occupancy; simultaneous push and pop leave occupancy unchanged.
    always_ff @(posedge clk) begin
        if (rst) begin
            tag_wr_ptr <= '0;
            tag_rd_ptr <= '0;
            tag_cnt    <= '0;
        end else begin
            if (tag_push) tag_wr_ptr <= tag_wr_ptr + TAGW'(1);
            if (tag_pop)  tag_rd_ptr <= tag_rd_ptr + TAGW'(1);
            case ({tag_push, tag_pop})
                2'b10:   tag_cnt <= tag_cnt + (TAGW+1)'(1);
                2'b01:   tag_cnt <= tag_cnt - (TAGW+1)'(1);
                default: tag_cnt <= tag_cnt;
            endcase
        end
    end

    // Tag storage: remembers which agent issued each outstanding read.
    always_ff @(posedge clk) begin
        if (tag_push) begin
            tag_mem[tag_wr_ptr] <= grant_id_q;
        end
    end

    // Response steering: the FIFO head names the agent, data is shared by all agents.
    always_comb begin
        agt_rd_valid = '0;
        if (tag_pop) begin
            agt_rd_valid[tag_head] = 1'b1;
        end
        for (int i = 0; i < NUM_AGENTS; i++) begin
            agt_rdata[i] = sys_mem_rdata;
        end
    end

    // Sticky flag for a response that arrives with no read outstanding.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_orphan_rd <= 1'b0;
        end else if (sys_mem_rd_valid && tag_empty) begin
            err_orphan_rd <= 1'b1;
        end
    end

`ifdef SYS_MEM_ARB_STATS_EN
    logic [NUM_AGENTS-1:0][15:0] stat_q;

    // Per-agent accepted-beat counters, saturating; clear has priority over counting.
    always_ff @(posedge clk) begin
        if (rst || stat_clr) begin
            stat_q <= '0;
        end else if (accept && (stat_q[grant_id_q] != 16'hFFFF)) begin
            stat_q[grant_id_q] <= stat_q[grant_id_q] + 16'd1;
        end
    end

    assign stat_beats = stat_q;
`else
    logic unused_stat_clr;

    assign unused_stat_clr = stat_clr;
    assign stat_beats      = '0;
`endif

endmodule

// File: doc/sys_mem_arb.md
SYS_MEM_ARB -- requirements
Module: sys_mem_arb

Interface
REQ-001 SHALL have parameter NUM_AGENTS, default 4, number of requesting sys_mem agents (2..8).
REQ-002 SHALL have parameter SYS_MEM_DATA_W, default 32, memory data width.
REQ-003 SHALL have parameter SYS_MEM_ADDR_W, default 27, memory address width.
REQ-004 SHALL have parameter ARB_MODE, default 0, 0=round-robin, 1=fixed priority (lowest index wins).
REQ-005 SHALL have parameter BURST_MAX, default 8, max accepted beats per grant before re-arbitration.
REQ-006 SHALL have parameter RD_TAG_DEPTH, default 16, outstanding-read tag FIFO depth (power of 2).
REQ-007 SHALL have ports: clk  in  1  sole clock; rst  in  1  synchronous active-high reset.
REQ-008 SHALL have ports: agt_wren, agt_rden  in  NUM_AGENTS  per-agent write/read request.
REQ-009 SHALL have ports: agt_addr  in  SYS_MEM_ADDR_W x NUM_AGENTS; agt_wdata  in  SYS_MEM_DATA_W x NUM_AGENTS.
REQ-010 SHALL have ports: agt_wait  out  NUM_AGENTS  stall; agt_rd_valid  out  NUM_AGENTS; agt_rdata  out  SYS_MEM_DATA_W x NUM_AGENTS.
REQ-011 SHALL have ports: sys_mem_wren, sys_mem_rden  out  1; sys_mem_addr  out  SYS_MEM_ADDR_W; sys_mem_wdata  out  SYS_MEM_DATA_W.
REQ-012 SHALL have ports: sys_mem_wait  in  1; sys_mem_rd_valid  in  1; sys_mem_rdata  in  SYS_MEM_DATA_W.
REQ-013 SHALL have ports: err_orphan_rd  out  1  sticky error; stat_clr  in  1; stat_beats  out  16 x NUM_AGENTS.

Function
REQ-014 Agent request SHALL be agt_wren[i] | agt_rden[i]; wren AND rden together SHALL forward wren only, rden masked.
REQ-015 FSM SHALL have states IDLE and OWN; reset state IDLE.
REQ-016 IDLE: any request -> register winner in grant_id, enter OWN next cycle; no memory command issued in IDLE.
REQ-017 Winner, ARB_MODE=0: first requester scanning from rr_ptr+1 with wrap; ARB_MODE=1: lowest requesting index.
REQ-018 OWN: granted agent's wren/rden/addr/wdata SHALL drive sys_mem_* combinationally; non-granted agents see zero command.
REQ-019 A beat SHALL be accepted when granted command asserted and sys_mem_wait=0.
REQ-020 agt_wait[i] SHALL be 1 unless i==grant_id in OWN, sys_mem_wait=0, and (for reads) tag FIFO not full.
REQ-021 Read when tag FIFO full SHALL be held (sys_mem_rden=0, agent waits); writes unaffected.
REQ-022 OWN -> IDLE when granted agent drops request or accepted-beat count reaches BURST_MAX on the accepting cycle; rr_ptr <= grant_id on exit.
REQ-023 Each accepted read SHALL push grant_id into tag FIFO; push and pop in same cycle SHALL keep occupancy unchanged.
REQ-024 sys_mem_rd_valid SHALL pop FIFO and assert agt_rd_valid[head] with sys_mem_rdata same cycle (zero latency); other agt_rd_valid=0.
REQ-025 sys_mem_rd_valid with FIFO empty SHALL be dropped and set err_orphan_rd until rst.
REQ-026 Single-requester case SHALL sustain BURST_MAX beats per 1 + BURST_MAX cycles (one idle arbitration cycle).

Reset
REQ-027 On rst: FSM IDLE, grant_id=0, rr_ptr=NUM_AGENTS-1, beat count 0, tag FIFO emptied, err_orphan_rd=0, stat_beats=0.
REQ-028 During/after rst: sys_mem_wren=sys_mem_rden=0, all agt_wait=1, all agt_rd_valid=0; in-flight reads discarded, later responses flagged orphan.

Configuration
REQ-029 Macro SYS_MEM_ARB_STATS_EN defined: stat_beats[i] SHALL count accepted beats of agent i, saturate at 16'hFFFF, clear to 0 on stat_clr (clear wins over simultaneous increment).
REQ-030 Macro undefined: stat_beats SHALL be constant 0, stat_clr ignored, no counter logic synthesised.

Verification
REQ-031 NUM_AGENTS=4, RR, agents 0-3 request continuously, BURST_MAX=8 -> grants 0,1,2,3,0 each 8 beats, one idle cycle between.
REQ-032 ARB_MODE=1, agents 1 and 3 requesting -> agent 1 owns until it drops request; agent 3 starves meanwhile.
REQ-033 Agent 2 issues 16 reads, sys_mem_rd_valid withheld -> 17th read stalled (agt_wait[2]=1, sys_mem_rden=0); one response releases it.
REQ-034 Interleaved reads agents 0,1,0 then 3 responses 0xA,0xB,0xC -> agt_rd_valid[0]=0xA, [1]=0xB, [0]=0xC in order.
REQ-035 sys_mem_rd_valid pulse with empty FIFO -> err_orphan_rd=1, no agt_rd_valid; stays 1 until rst.
REQ-036 STATS_EN: 70000 agent-0 beats -> stat_beats[0]=16'hFFFF; stat_clr -> 0 next cycle; without macro always 0.
